// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundles the two byte-stream requesters, the UART TX FIFO write port and
// the arbiter status outputs into one interface.
//
//   req0_valid/data/last  requester 0 (game-state frames) byte offer
//   req0_ready            requester 0 byte accepted this cycle
//   req1_valid/data/last  requester 1 (link-sync frames) byte offer
//   req1_ready            requester 1 byte accepted this cycle
//   tx_full               UART TX FIFO full
//   wr_uart, w_data       registered one-cycle write strobe and byte
//   grant                 one-hot current owner, 00 when idle
//   frame_done            pulse when a frame terminates
//   frame_err             pulse when a frame is cut at the length limit
//
// Modports:
//   master  requester/FIFO side (drives offers and tx_full)
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;

  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;

  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [1:0] grant;
  logic       frame_done;
  logic       frame_err;

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output tx_full,
    input  req0_ready, req1_ready,
    input  wr_uart, w_data, grant, frame_done, frame_err
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  tx_full,
    output req0_ready, req1_ready,
    output wr_uart, w_data, grant, frame_done, frame_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART TX FIFO between two framed byte sources. A requester is
// granted for a whole frame (until a byte with last=1, or until MAX_FRAME
// bytes have been taken, whichever comes first); the grant never moves
// mid-frame. Ties in IDLE go to the requester not granted last.
//
// Bytes are forwarded through a register: a transfer in cycle N produces
// wr_uart=1 / w_data=byte in cycle N+1. Ready is withheld while wr_uart is
// high so the FIFO's full flag has a cycle to reflect the write before the
// next byte is accepted; peak throughput is one byte every two cycles.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    uart_tx_arbiter_if.slave (requesters, FIFO port, status)
//
// Parameters:
//   MAX_FRAME  maximum bytes accepted per grant before a forced frame end
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned MAX_FRAME = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MAX_FRAME + 1);
  // Count value held when the MAX_FRAME-th byte is being transferred.
  localparam logic [CntW-1:0] LastIdx = CntW'(MAX_FRAME - 1);

  // State encoding doubles as the one-hot grant output.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrant0 = 2'b01,
    StGrant1 = 2'b10
  } state_e;

  state_e          state_q;
  logic            last_owner_q;  // 0: requester 0 granted last, 1: requester 1
  logic [CntW-1:0] cnt_q;
  logic            wr_uart_q;
  logic [7:0]      w_data_q;
  logic            frame_done_q;
  logic            frame_err_q;

  logic       rdy0;
  logic       rdy1;
  logic       xfer0;
  logic       xfer1;
  logic       xfer;
  logic       x_last;
  logic [7:0] x_data;

  // Handshake. The !wr_uart_q term inserts the mandatory gap after each write.
  always_comb begin
    rdy0   = (state_q == StGrant0) && !bus.tx_full && !wr_uart_q;
    rdy1   = (state_q == StGrant1) && !bus.tx_full && !wr_uart_q;
    xfer0  = bus.req0_valid && rdy0;
    xfer1  = bus.req1_valid && rdy1;
    xfer   = xfer0 || xfer1;
    x_data = xfer1 ? bus.req1_data : bus.req0_data;
    x_last = xfer1 ? bus.req1_last : bus.req0_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;  // requester 0 wins the first tie
      cnt_q        <= '0;
      wr_uart_q    <= 1'b0;
      w_data_q     <= 8'h00;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_uart_q    <= xfer;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;

      // w_data holds its value between transfers (including under tx_full).
      if (xfer) begin
        w_data_q <= x_data;
        cnt_q    <= cnt_q + CntW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (bus.req0_valid && (!bus.req1_valid || last_owner_q)) begin
            state_q      <= StGrant0;
            last_owner_q <= 1'b0;
            cnt_q        <= '0;
          end else if (bus.req1_valid) begin
            state_q      <= StGrant1;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
          end
        end
        StGrant0, StGrant1: begin
          if (xfer) begin
            if (x_last) begin
              state_q      <= StIdle;
              frame_done_q <= 1'b1;
            end else if (cnt_q == LastIdx) begin
              // Over-long frame: cut it; the rest re-arbitrates as a new frame.
              state_q      <= StIdle;
              frame_done_q <= 1'b1;
              frame_err_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.wr_uart    = wr_uart_q;
  assign bus.w_data     = w_data_q;
  assign bus.grant      = state_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed frame scenarios followed by a randomized run. A cycle-level
// behavioural model (owner index, byte count, pending write) predicts every
// output on every falling edge; directed scenarios also pin literal results.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int unsigned MaxF = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.MAX_FRAME(MaxF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester byte queues, entries are {last, data}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         took0 = 0;
  bit         took1 = 0;
  int         vprob = 100;

  // Observation logs.
  logic [7:0] wlog[$];
  int         wcyc[$];
  logic [1:0] glog[$];
  int         gcyc[$];
  logic [1:0] prev_g = 2'b00;
  int         ndone = 0;
  int         nerr  = 0;
  int         errcyc = -1;
  int         cyc = 0;

  // Reference model state.
  int m_owner = -1;  // -1 idle, else requester index
  int m_prev  = 1;
  int m_cnt   = 0;
  int m_wdata = 0;
  bit m_wr = 0, m_done = 0, m_err = 0;
  bit e_r0, e_r1;
  int xo;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester driver.
  initial begin
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (took0 && q0.size() > 0) void'(q0.pop_front());
      if (took1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0 && $urandom_range(99) < vprob) begin
        bus.req0_valid = 1'b1; bus.req0_data = q0[0][7:0]; bus.req0_last = q0[0][8];
      end else begin
        bus.req0_valid = 1'b0; bus.req0_data = 8'($urandom); bus.req0_last = 1'($urandom);
      end
      if (q1.size() > 0 && $urandom_range(99) < vprob) begin
        bus.req1_valid = 1'b1; bus.req1_data = q1[0][7:0]; bus.req1_last = q1[0][8];
      end else begin
        bus.req1_valid = 1'b0; bus.req1_data = 8'($urandom); bus.req1_last = 1'($urandom);
      end
    end
  end

  // Monitor + model compare.
  initial forever begin
    @(negedge clk);
    took0 = bus.req0_valid && bus.req0_ready;
    took1 = bus.req1_valid && bus.req1_ready;
    if (rst_n && bus.wr_uart) begin
      wlog.push_back(bus.w_data);
      wcyc.push_back(cyc);
    end
    if (bus.grant != prev_g) begin
      glog.push_back(bus.grant);
      gcyc.push_back(cyc);
      prev_g = bus.grant;
    end
    if (bus.frame_done) ndone++;
    if (bus.frame_err) begin
      nerr++;
      errcyc = cyc;
    end

    if (!rst_n) begin
      m_owner = -1; m_prev = 1; m_cnt = 0; m_wdata = 0;
      m_wr = 0; m_done = 0; m_err = 0;
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_wr_uart", 32'(bus.wr_uart), 0);
      check("rst_w_data", 32'(bus.w_data), 0);
      check("rst_frame_done", 32'(bus.frame_done), 0);
      check("rst_frame_err", 32'(bus.frame_err), 0);
      check("rst_ready0", 32'(bus.req0_ready), 0);
      check("rst_ready1", 32'(bus.req1_ready), 0);
    end else begin
      e_r0 = (m_owner == 0) && !bus.tx_full && !m_wr;
      e_r1 = (m_owner == 1) && !bus.tx_full && !m_wr;
      check("grant", 32'(bus.grant), (m_owner < 0) ? 0 : (1 << m_owner));
      check("wr_uart", 32'(bus.wr_uart), 32'(m_wr));
      check("w_data", 32'(bus.w_data), m_wdata);
      check("frame_done", 32'(bus.frame_done), 32'(m_done));
      check("frame_err", 32'(bus.frame_err), 32'(m_err));
      check("ready0", 32'(bus.req0_ready), 32'(e_r0));
      check("ready1", 32'(bus.req1_ready), 32'(e_r1));

      xo = -1;
      if (e_r0 && bus.req0_valid) xo = 0;
      else if (e_r1 && bus.req1_valid) xo = 1;
      m_done = 0;
      m_err  = 0;
      m_wr   = (xo >= 0);
      if (xo >= 0) begin
        m_wdata = (xo == 1) ? int'(bus.req1_data) : int'(bus.req0_data);
        m_cnt++;
        if ((xo == 1) ? bus.req1_last : bus.req0_last) begin
          m_owner = -1; m_done = 1;
        end else if (m_cnt == MaxF) begin
          m_owner = -1; m_done = 1; m_err = 1;
        end
      end else if (m_owner < 0) begin
        if (bus.req0_valid && bus.req1_valid) m_owner = 1 - m_prev;
        else if (bus.req0_valid) m_owner = 0;
        else if (bus.req1_valid) m_owner = 1;
        if (m_owner >= 0) begin
          m_prev = m_owner;
          m_cnt  = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); glog.delete(); gcyc.delete();
    ndone = 0; nerr = 0; errcyc = -1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(n < limit), 1);
    tick(6);
  endtask

  task automatic wait_wr(input string name, input int k, input int limit);
    int n = 0;
    while (wlog.size() < k && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(n < limit), 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] exp_b[$];
    logic [7:0] sent0[$], sent1[$], got0[$], got1[$];
    logic [1:0] nz[$];
    int w0, len, s0, s1, n;

    rst_n = 1'b1;
    bus.tx_full = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single frame A1,A2,A3.
    clear_logs();
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    wait_drain("t1_timeout", 100);
    check("t1_nbytes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("t1_b0", 32'(wlog[0]), 32'hA1);
      check("t1_b1", 32'(wlog[1]), 32'hA2);
      check("t1_b2", 32'(wlog[2]), 32'hA3);
      check("t1_gap01", wcyc[1] - wcyc[0], 2);
      check("t1_gap12", wcyc[2] - wcyc[1], 2);
    end
    check("t1_done", ndone, 1);
    check("t1_err", nerr, 0);
    check("t1_ngrant", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t1_g0", 32'(glog[0]), 1);
      check("t1_g1", 32'(glog[1]), 0);
    end

    // Tie from reset release.
    rst_n = 1'b0;
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
    q0.push_back({1'b0, 8'h13}); q0.push_back({1'b1, 8'h14});
    q1.push_back({1'b0, 8'h21}); q1.push_back({1'b1, 8'h22});
    q1.push_back({1'b0, 8'h23}); q1.push_back({1'b1, 8'h24});
    tick(2);
    clear_logs();
    rst_n = 1'b1;
    wait_drain("t2_timeout", 200);
    foreach (glog[i]) if (glog[i] != 2'b00) nz.push_back(glog[i]);
    check("t2_ngrant", nz.size(), 4);
    if (nz.size() == 4) begin
      check("t2_g0", 32'(nz[0]), 1);
      check("t2_g1", 32'(nz[1]), 2);
      check("t2_g2", 32'(nz[2]), 1);
      check("t2_g3", 32'(nz[3]), 2);
    end
    exp_b = '{8'h11, 8'h12, 8'h21, 8'h22, 8'h13, 8'h14, 8'h23, 8'h24};
    check("t2_nbytes", wlog.size(), 8);
    if (wlog.size() == 8) foreach (exp_b[i]) check("t2_byte", 32'(wlog[i]), 32'(exp_b[i]));
    check("t2_done", ndone, 4);

    // Backpressure mid-frame.
    clear_logs();
    q0.push_back({1'b0, 8'hB1}); q0.push_back({1'b0, 8'hB2});
    q0.push_back({1'b0, 8'hB3}); q0.push_back({1'b1, 8'hB4});
    wait_wr("t3_wait", 2, 100);
    bus.tx_full = 1'b1;
    w0 = wlog.size();
    tick(5);
    check("t3_stall_no_wr", wlog.size(), w0);
    check("t3_stall_grant", 32'(bus.grant), 1);
    check("t3_stall_done", ndone, 0);
    bus.tx_full = 1'b0;
    wait_drain("t3_timeout", 100);
    exp_b = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    check("t3_nbytes", wlog.size(), 4);
    if (wlog.size() == 4) foreach (exp_b[i]) check("t3_byte", 32'(wlog[i]), 32'(exp_b[i]));
    check("t3_done", ndone, 1);

    // Overlength frame on requester 1.
    clear_logs();
    for (int i = 1; i <= 6; i++) q1.push_back({1'b0, 8'(8'hC0 + i)});
    wait_drain("t4_timeout", 100);
    check("t4_nbytes", wlog.size(), 6);
    if (wlog.size() == 6) for (int i = 0; i < 6; i++) check("t4_byte", 32'(wlog[i]), 32'hC1 + i);
    check("t4_err", nerr, 1);
    check("t4_done", ndone, 1);
    if (wlog.size() == 6) check("t4_err_with_4th", errcyc, wcyc[3]);
    check("t4_ngrant", glog.size(), 3);
    if (glog.size() == 3 && wlog.size() == 6) begin
      check("t4_g0", 32'(glog[0]), 2);
      check("t4_g1", 32'(glog[1]), 0);
      check("t4_g2", 32'(glog[2]), 2);
      check("t4_5th_after_regrant", 32'(wcyc[4] > gcyc[2]), 1);
    end

    // Reset mid-frame.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_logs();
    q0.push_back({1'b0, 8'hD1}); q0.push_back({1'b0, 8'hD2});
    q0.push_back({1'b0, 8'hD3}); q0.push_back({1'b1, 8'hD4});
    wait_wr("t5_wait", 2, 100);
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("t5_imm_grant", 32'(bus.grant), 0);
    check("t5_imm_wr", 32'(bus.wr_uart), 0);
    check("t5_imm_w_data", 32'(bus.w_data), 0);
    check("t5_imm_done", 32'(bus.frame_done), 0);
    check("t5_imm_err", 32'(bus.frame_err), 0);
    check("t5_imm_ready0", 32'(bus.req0_ready), 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("t5_no_done", ndone, 0);
    clear_logs();
    q0.push_back({1'b0, 8'hE1}); q0.push_back({1'b1, 8'hE2});
    wait_drain("t5_timeout", 100);
    check("t5_nbytes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t5_b0", 32'(wlog[0]), 32'hE1);
      check("t5_b1", 32'(wlog[1]), 32'hE2);
    end
    check("t5_done", ndone, 1);

    // Randomized traffic.
    clear_logs();
    vprob = 70;
    s0 = 0;
    s1 = 0;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        q0.push_back({1'(b == len - 1), 1'b0, 7'(s0)});
        sent0.push_back({1'b0, 7'(s0)});
        s0++;
      end
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        q1.push_back({1'(b == len - 1), 1'b1, 7'(s1)});
        sent1.push_back({1'b1, 7'(s1)});
        s1++;
      end
    end
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20000) begin
      bus.tx_full = ($urandom_range(99) < 20);
      tick(1);
      n++;
    end
    check("t6_timeout", 32'(n < 20000), 1);
    bus.tx_full = 1'b0;
    tick(10);
    foreach (wlog[i]) begin
      if (wlog[i][7]) got1.push_back(wlog[i]);
      else got0.push_back(wlog[i]);
    end
    check("t6_n0", got0.size(), sent0.size());
    check("t6_n1", got1.size(), sent1.size());
    if (got0.size() == sent0.size()) foreach (sent0[i]) check("t6_r0", 32'(got0[i]), 32'(sent0[i]));
    if (got1.size() == sent1.size()) foreach (sent1[i]) check("t6_r1", 32'(got1[i]), 32'(sent1[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
